// File: rtl/seg_scan_ctrl_pkg.sv
// Shared constants for the seven-segment scan controller: sizes, blanking
// values, FSM state encoding, write payload and the hex-to-segment table.
package seg_scan_ctrl_pkg;

  localparam int unsigned MAX_DIG = 8;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned NIB_W   = 4;
  localparam int unsigned SEG_W   = 7;
  localparam int unsigned PH_W    = 2;
  localparam int unsigned BRT_W   = 2;

  localparam logic [MAX_DIG-1:0] AN_OFF  = 8'hFF;
  localparam logic [SEG_W-1:0]   SEG_OFF = 7'h7F;
  localparam logic [PH_W-1:0]    PH_LAST = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LIT  = 2'd1,
    ST_DARK = 2'd2
  } scan_state_t;

  typedef struct packed {
    logic [IDX_W-1:0] addr;
    logic [NIB_W-1:0] data;
  } wr_req_t;

  // Active-low segments {g,f,e,d,c,b,a}.
  function automatic logic [SEG_W-1:0] seg_decode(input logic [NIB_W-1:0] nib);
    logic [SEG_W-1:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_tick.sv
// Prescaler: counts 0..CLK_DIV-1 and raises tick_c during the terminal count.
// Ports: clk_in (clock), rst (async active-low reset), tick_c (scan tick).
module seg_tick_gen #(
  parameter int unsigned CLK_DIV = 100000
) (
  input  logic clk_in,
  input  logic rst,
  output logic tick_c
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] count;

  assign tick_c = (count == CNT_MAX);

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst)        count <= '0;
    else if (tick_c) count <= '0;
    else             count <= count + CNT_W'(1);
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with double-buffered digit data.
// Ports: clk_in/rst clock and async active-low reset; wr_en/wr_addr/wr_data
// shadow write; commit copies shadow to active at the next frame boundary;
// wr_ready low while a commit is pending; digit_en enable mask; bright duty;
// AN/seven_seg active-low registered drive; frame_done boundary pulse.
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int unsigned CLK_DIV = 100000,
  parameter int unsigned N_DIG   = 8
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [IDX_W-1:0]     wr_addr,
  input  logic [NIB_W-1:0]     wr_data,
  output logic                 wr_ready,
  input  logic                 commit,
  input  logic [MAX_DIG-1:0]   digit_en,
  input  logic [BRT_W-1:0]     bright,
  output logic [MAX_DIG-1:0]   AN,
  output logic [SEG_W-1:0]     seven_seg,
  output logic                 frame_done
);

  localparam int unsigned NDIG = (N_DIG > MAX_DIG) ? MAX_DIG : N_DIG;

  scan_state_t        state, state_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic [PH_W-1:0]    phase, phase_nxt;
  logic [BRT_W-1:0]   bright_q, bright_nxt;
  logic [NIB_W-1:0]   shadow [MAX_DIG];
  logic [NIB_W-1:0]   active [MAX_DIG];
  logic               commit_pending;
  logic               tick_c;
  logic               copy_c;
  logic               frame_c;
  logic               wr_acc_c;
  logic               commit_acc_c;
  logic [MAX_DIG-1:0] mask_c;
  logic [MAX_DIG-1:0] an_c;
  logic [SEG_W-1:0]   seg_c;
  logic [NIB_W-1:0]   nib_c;
  wr_req_t            wr_req_c;

  seg_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk_in (clk_in),
    .rst    (rst),
    .tick_c (tick_c)
  );

  // Lowest enabled digit index.
  function automatic logic [IDX_W-1:0] first_en(input logic [MAX_DIG-1:0] m);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int k = int'(NDIG) - 1; k >= 0; k--) begin
      if (m[k]) r = IDX_W'(k);
    end
    return r;
  endfunction

  // Next enabled digit after cur in wrap-around order; cur itself if it is the only one.
  function automatic logic [IDX_W-1:0] next_en(input logic [IDX_W-1:0] cur,
                                               input logic [MAX_DIG-1:0] m);
    logic [IDX_W-1:0] r;
    int               cand;
    r = cur;
    for (int k = int'(NDIG); k >= 1; k--) begin
      cand = (int'(cur) + k) % int'(NDIG);
      if (m[cand]) r = IDX_W'(cand);
    end
    return r;
  endfunction

  // Enable mask restricted to implemented digits.
  always_comb begin
    mask_c = '0;
    for (int i = 0; i < int'(MAX_DIG); i++) begin
      mask_c[i] = digit_en[i] && (i < int'(NDIG));
    end
  end

  assign wr_req_c     = '{addr: wr_addr, data: wr_data};
  assign wr_acc_c     = wr_en && wr_ready && (32'(wr_req_c.addr) < NDIG);
  assign commit_acc_c = commit && wr_ready;

  // Scan FSM next state; everything moves only on tick.
  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    phase_nxt  = phase;
    bright_nxt = bright_q;
    frame_c    = 1'b0;
    copy_c     = 1'b0;
    if (tick_c) begin
      unique case (state)
        ST_IDLE: begin
          copy_c = commit_pending;
          if (|mask_c) begin
            state_nxt  = ST_LIT;
            idx_nxt    = first_en(mask_c);
            phase_nxt  = '0;
            bright_nxt = bright;
          end
        end
        ST_LIT, ST_DARK: begin
          if (phase == PH_LAST) begin
            phase_nxt = '0;
            if (|mask_c) begin
              state_nxt  = ST_LIT;
              idx_nxt    = next_en(idx, mask_c);
              bright_nxt = bright;
              // Wrapping to an index not above the current one closes the frame.
              if (idx_nxt <= idx) begin
                frame_c = 1'b1;
                copy_c  = commit_pending;
              end
            end else begin
              state_nxt = ST_IDLE;
            end
          end else begin
            phase_nxt = phase + PH_W'(1);
            if (state == ST_LIT && phase == bright_q) state_nxt = ST_DARK;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Drive values for the coming cycle; a committing boundary shows the new data at once.
  always_comb begin
    an_c  = AN_OFF;
    seg_c = SEG_OFF;
    nib_c = copy_c ? shadow[idx_nxt] : active[idx_nxt];
    if (state_nxt == ST_LIT) begin
      an_c  = ~(MAX_DIG'(1) << idx_nxt);
      seg_c = seg_decode(nib_c);
    end
  end

  // FSM state register.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      idx      <= '0;
      phase    <= '0;
      bright_q <= '0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      phase    <= phase_nxt;
      bright_q <= bright_nxt;
    end
  end

  // Registered display outputs.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      AN         <= AN_OFF;
      seven_seg  <= SEG_OFF;
      frame_done <= 1'b0;
    end else begin
      AN         <= an_c;
      seven_seg  <= seg_c;
      frame_done <= frame_c;
    end
  end

  // Shadow/active buffers and commit handshake; wr_ready mirrors !commit_pending.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(MAX_DIG); i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
      commit_pending <= 1'b0;
      wr_ready       <= 1'b1;
    end else begin
      if (wr_acc_c) shadow[wr_req_c.addr] <= wr_req_c.data;
      if (copy_c) begin
        for (int i = 0; i < int'(MAX_DIG); i++) active[i] <= shadow[i];
        commit_pending <= 1'b0;
        wr_ready       <= 1'b1;
      end else if (commit_acc_c) begin
        commit_pending <= 1'b1;
        wr_ready       <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl (CLK_DIV=4): expected display slots are
// queued as stimulus is applied and compared cycle by cycle at negedge.
module tb_seg_scan_ctrl;

  logic       clk_in = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [3:0] wr_data = '0;
  logic       wr_ready;
  logic       commit = 1'b0;
  logic [7:0] digit_en = '0;
  logic [1:0] bright = '0;
  logic [7:0] AN;
  logic [6:0] seven_seg;
  logic       frame_done;

  always #5 clk_in = ~clk_in;

  seg_scan_ctrl #(.CLK_DIV(4), .N_DIG(8)) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .commit     (commit),
    .digit_en   (digit_en),
    .bright     (bright),
    .AN         (AN),
    .seven_seg  (seven_seg),
    .frame_done (frame_done)
  );

  typedef struct packed {
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        fd;
    logic [15:0] ncyc;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [6:0] seg_ref [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_tests++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, want, $time);
    end
  endtask

  task automatic push(input logic [7:0] an, input logic [6:0] seg, input logic fd, input int n);
    sb.push_back('{an, seg, fd, 16'(n)});
  endtask

  // Pop each expected slot segment and compare it for its whole duration.
  task automatic run_sb();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      for (int c = 0; c < int'(e.ncyc); c++) begin
        chk("an", 32'(AN), 32'(e.an));
        chk("seg", 32'(seven_seg), 32'(e.seg));
        chk("frame_done", 32'(frame_done), (c == 0) ? 32'(e.fd) : 32'd0);
        @(negedge clk_in);
      end
    end
  endtask

  task automatic wait_fd(input int lim);
    int k = 0;
    while (frame_done !== 1'b1 && k < lim) begin
      @(negedge clk_in);
      k++;
    end
    chk("fd_wait", 32'(frame_done), 32'd1);
  endtask

  function automatic logic [7:0] an_of(input int i);
    logic [7:0] one = 8'h01;
    return ~(one << i);
  endfunction

  initial begin
    // Reset state
    repeat (3) @(negedge clk_in);
    chk("rst_an", 32'(AN), 32'hFF);
    chk("rst_seg", 32'(seven_seg), 32'h7F);
    chk("rst_fd", 32'(frame_done), 32'd0);
    chk("rst_rdy", 32'(wr_ready), 32'd1);
    rst = 1'b1;

    // Load 0..7, commit, full scan at full brightness
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_addr = 3'(i); wr_data = 4'(i);
      @(negedge clk_in);
    end
    wr_en = 1'b0; commit = 1'b1;
    @(negedge clk_in);
    commit = 1'b0;
    chk("t1_rdy_pend", 32'(wr_ready), 32'd0);
    digit_en = 8'hFF; bright = 2'd3;
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 8; i++) push(an_of(i), seg_ref[i], i == 0, 16);
    wait_fd(300);
    chk("t1_rdy", 32'(wr_ready), 32'd1);
    run_sb();

    // Sparse mask, minimum brightness
    digit_en = 8'b0010_0100; bright = 2'd0;
    @(negedge clk_in);
    wait_fd(200);
    for (int f = 0; f < 2; f++) begin
      push(an_of(2), seg_ref[2], 1'b1, 4);
      push(8'hFF, 7'h7F, 1'b0, 12);
      push(an_of(5), seg_ref[5], 1'b0, 4);
      push(8'hFF, 7'h7F, 1'b0, 12);
    end
    run_sb();

    // Mid-frame commit carrying a write; following write is refused
    push(an_of(2), seg_ref[2], 1'b1, 4);
    run_sb();
    chk("t3_rdy_before", 32'(wr_ready), 32'd1);
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 4'hA; commit = 1'b1;
    @(negedge clk_in);
    commit = 1'b0; wr_addr = 3'd5; wr_data = 4'hF;
    chk("t3_rdy_pend", 32'(wr_ready), 32'd0);
    @(negedge clk_in);
    wr_en = 1'b0;
    chk("t3_rdy_pend2", 32'(wr_ready), 32'd0);
    push(8'hFF, 7'h7F, 1'b0, 10);
    push(an_of(5), seg_ref[5], 1'b0, 4);
    push(8'hFF, 7'h7F, 1'b0, 12);
    run_sb();
    chk("t3_rdy_boundary", 32'(wr_ready), 32'd1);
    push(an_of(2), seg_ref[10], 1'b1, 4);
    push(8'hFF, 7'h7F, 1'b0, 12);
    push(an_of(5), seg_ref[5], 1'b0, 4);
    push(8'hFF, 7'h7F, 1'b0, 12);
    run_sb();

    // Mask of zero drops to idle; then a single digit
    digit_en = 8'h00;
    push(an_of(2), seg_ref[10], 1'b1, 4);
    push(8'hFF, 7'h7F, 1'b0, 12);
    push(8'hFF, 7'h7F, 1'b0, 40);
    run_sb();
    digit_en = 8'h01; bright = 2'd3;
    push(8'hFF, 7'h7F, 1'b0, 4);
    push(an_of(0), seg_ref[0], 1'b0, 16);
    push(an_of(0), seg_ref[0], 1'b1, 16);
    run_sb();

    // Async reset mid-LIT with a commit pending
    repeat (2) @(negedge clk_in);
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 4'h7; commit = 1'b1;
    @(negedge clk_in);
    wr_en = 1'b0; commit = 1'b0;
    chk("t5_rdy_pend", 32'(wr_ready), 32'd0);
    chk("t5_an_lit", 32'(AN), 32'hFE);
    #2 rst = 1'b0;
    #1;
    chk("t5_async_an", 32'(AN), 32'hFF);
    chk("t5_async_seg", 32'(seven_seg), 32'h7F);
    chk("t5_async_fd", 32'(frame_done), 32'd0);
    chk("t5_async_rdy", 32'(wr_ready), 32'd1);
    repeat (2) @(negedge clk_in);
    rst = 1'b1;
    for (int k = 0; k < 20 && AN === 8'hFF; k++) @(negedge clk_in);
    chk("t5_an_after", 32'(AN), 32'hFE);
    chk("t5_seg_after", 32'(seven_seg), 32'(seg_ref[0]));
    commit = 1'b1;
    @(negedge clk_in);
    commit = 1'b0;
    wait_fd(40);
    chk("t5_seg_commit", 32'(seven_seg), 32'(seg_ref[0]));
    chk("t5_an_commit", 32'(AN), 32'hFE);
    chk("t5_rdy_commit", 32'(wr_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
